// File: rtl/rnd_chk_m.sv
// rnd_chk_m: self-synchronising LFSR sequence checker with lock tracking and error counting

// Polynomial descriptions shared with the generator so both link ends match.
package rndgen_pkg;
    typedef struct packed {
        logic [7:0]      TapeNum;
        logic [7:0][7:0] FB;
    } RndGenParams_t;

    localparam RndGenParams_t RndGen31 = '{TapeNum: 8'd31,
        FB: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd28, 8'd31}};
    localparam RndGenParams_t RndGen7 = '{TapeNum: 8'd7,
        FB: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd6, 8'd7}};
endpackage

module rnd_chk_m #(
    parameter rndgen_pkg::RndGenParams_t PARAMS = rndgen_pkg::RndGen31,
    parameter int LOCK_CNT = 64,
    parameter int LOSS_WIN = 256,
    parameter int LOSS_THR = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             din,
    input  logic             clr,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int N  = int'(PARAMS.TapeNum);
    localparam int FW = $clog2(N + 1);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int WW = $clog2(LOSS_WIN + 1);
    localparam int BW = $clog2(LOSS_THR + 1);

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t         state, state_nxt;
    logic [1:N]     hist;
    logic [FW-1:0]  fill_cnt;
    logic [GW-1:0]  good_cnt;
    logic [WW-1:0]  win_cnt;
    logic [BW-1:0]  bad_cnt;
    logic [8:0]     ch;
    logic           pred, mis, is_lk, fill_done, lmis, hit_lock, hit_loss, win_wrap;

    // A tap counts only if no zero terminator precedes it in the list.
    function automatic bit tap_live(input int k);
        for (int j = 0; j <= k; j++)
            if (PARAMS.FB[j] == 8'd0) return 1'b0;
        return 1'b1;
    endfunction

    // XNOR feedback chain, same function as the generator.
    assign ch[0] = 1'b1;
    for (genvar i = 0; i < 8; i++) begin : g_tap
        localparam int T = int'(PARAMS.FB[i]);
        if (tap_live(i)) begin : g_on
            assign ch[i+1] = ch[i] ~^ hist[T];
        end else begin : g_off
            assign ch[i+1] = ch[i];
        end
    end

    assign pred      = ch[8];
    assign mis       = din != pred;
    assign is_lk     = state == LOCKED;
    assign fill_done = fill_cnt == FW'(N);
    assign lmis      = in_valid && is_lk && mis;
    assign hit_lock  = in_valid && !is_lk && fill_done && !mis && good_cnt == GW'(LOCK_CNT - 1);
    assign hit_loss  = lmis && bad_cnt == BW'(LOSS_THR - 1);
    assign win_wrap  = win_cnt == WW'(LOSS_WIN - 1);
    assign locked    = is_lk;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= HUNT;
        else        state <= state_nxt;
    end

    // Lock acquisition after LOCK_CNT straight hits; loss after LOSS_THR misses in a window.
    always_comb begin
        state_nxt = state;
        state_nxt = is_lk ? (hit_loss ? HUNT : LOCKED) : (hit_lock ? LOCKED : HUNT);
    end

    // History, acquisition/loss counters, error pulse and saturating error count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist     <= '0;
            fill_cnt <= '0;
            good_cnt <= '0;
            win_cnt  <= '0;
            bad_cnt  <= '0;
            err      <= 1'b0;
            err_cnt  <= '0;
        end else begin
            err <= lmis;
            if (clr)
                err_cnt <= CNT_W'(lmis);
            else if (lmis && !(&err_cnt))
                err_cnt <= err_cnt + 1'b1;
            if (in_valid) begin
                hist <= {is_lk ? pred : din, hist[1:N-1]};
                if (!is_lk) begin
                    if (!fill_done)
                        fill_cnt <= fill_cnt + 1'b1;
                    else
                        good_cnt <= mis ? '0 : good_cnt + 1'b1;
                end else if (hit_loss) begin
                    fill_cnt <= '0;
                    good_cnt <= '0;
                    win_cnt  <= '0;
                    bad_cnt  <= '0;
                end else begin
                    win_cnt <= win_wrap ? '0 : win_cnt + 1'b1;
                    bad_cnt <= win_wrap ? '0 : bad_cnt + BW'(mis);
                end
            end
        end
    end
endmodule

// File: tb/tb_rnd_chk_m.sv
// tb_rnd_chk_m: directed checks of lock, error, loss, saturation, clear and async reset
module tb_rnd_chk_m;
    logic       clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, din = 1'b0, clr = 1'b0;
    logic       locked, err, locked4, err4;
    logic [7:0] err_cnt;
    logic [3:0] err_cnt4;
    logic [1:7] g = '0;
    int         total = 0, bad = 0;

    always #5 clk = ~clk;

    rnd_chk_m #(.PARAMS(rndgen_pkg::RndGen7), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .din(din), .clr(clr),
        .locked(locked), .err(err), .err_cnt(err_cnt));

    rnd_chk_m #(.PARAMS(rndgen_pkg::RndGen7), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .din(din), .clr(clr),
        .locked(locked4), .err(err4), .err_cnt(err_cnt4));

    // Reference generator: 7-bit XNOR LFSR, taps 7 and 6; optionally inverts the sent bit.
    task automatic step(input logic inv);
        logic b;
        b = ~(g[7] ^ g[6]);
        g = {b, g[1:6]};
        in_valid = 1'b1;
        din = b ^ inv;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clr = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (locked !== 1'b0 || err !== 1'b0 || err_cnt !== 8'd0 || locked4 !== 1'b0 || err_cnt4 !== 4'd0) begin
            bad++;
            $display("FAIL reset: locked=%b err=%b cnt=%0d cnt4=%0d required 0 0 0 0", locked, err, err_cnt, err_cnt4);
        end
        rst_n = 1'b1;
    endtask

    // Clean stream from HUNT: locked must rise after exactly 71 valid bits.
    task automatic test_lock(input string tag, input bit gaps, input logic [7:0] exp_cnt, input logic [3:0] exp_cnt4);
        int seen = 0;
        for (int k = 1; k <= 71; k++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 5)) begin
                    @(posedge clk);
                    #1;
                    if (err || err4) seen++;
                end
            end
            step(1'b0);
            if (err || err4) seen++;
            if (k == 70) begin
                total++;
                if (locked !== 1'b0 || locked4 !== 1'b0) begin
                    bad++;
                    $display("FAIL %s early_lock: locked=%b after 70 bits, required 0", tag, locked);
                end
            end
        end
        total++;
        if (locked !== 1'b1 || locked4 !== 1'b1) begin
            bad++;
            $display("FAIL %s lock: locked=%b locked4=%b after 71 bits, required 1", tag, locked, locked4);
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL %s no_err: %0d err pulses, required 0", tag, seen);
        end
        total++;
        if (err_cnt !== exp_cnt || err_cnt4 !== exp_cnt4) begin
            bad++;
            $display("FAIL %s cnt: err_cnt=%0d/%0d required %0d/%0d", tag, err_cnt, err_cnt4, exp_cnt, exp_cnt4);
        end
    endtask

    task automatic test_single_err();
        repeat (3) step(1'b0);
        step(1'b1);
        total++;
        if (err !== 1'b1 || err_cnt !== 8'd1 || locked !== 1'b1) begin
            bad++;
            $display("FAIL single_err: err=%b cnt=%0d locked=%b required 1 1 1", err, err_cnt, locked);
        end
        step(1'b0);
        total++;
        if (err !== 1'b0 || err_cnt !== 8'd1 || locked !== 1'b1) begin
            bad++;
            $display("FAIL single_err_after: err=%b cnt=%0d locked=%b required 0 1 1", err, err_cnt, locked);
        end
    endtask

    // 5 locked bits so far; 251 more closes the first window, then 16 misses in the next.
    task automatic test_loss();
        repeat (251) step(1'b0);
        clr = 1'b1;
        step(1'b0);
        total++;
        if (err_cnt !== 8'd0 || err_cnt4 !== 4'd0) begin
            bad++;
            $display("FAIL clr: err_cnt=%0d/%0d required 0/0", err_cnt, err_cnt4);
        end
        repeat (15) step(1'b1);
        total++;
        if (locked !== 1'b1 || err_cnt !== 8'd15 || err_cnt4 !== 4'd15) begin
            bad++;
            $display("FAIL loss_15: locked=%b cnt=%0d/%0d required 1 15/15", locked, err_cnt, err_cnt4);
        end
        step(1'b1);
        total++;
        if (locked !== 1'b0 || err !== 1'b1 || err_cnt !== 8'd16 || err_cnt4 !== 4'd15) begin
            bad++;
            $display("FAIL loss_16: locked=%b err=%b cnt=%0d/%0d required 0 1 16/15", locked, err, err_cnt, err_cnt4);
        end
        test_lock("relock", 1'b0, 8'd16, 4'd15);
    endtask

    task automatic test_sat_clr();
        step(1'b1);
        total++;
        if (err_cnt !== 8'd17 || err_cnt4 !== 4'd15 || err4 !== 1'b1) begin
            bad++;
            $display("FAIL saturate: cnt=%0d/%0d err4=%b required 17/15 1", err_cnt, err_cnt4, err4);
        end
        clr = 1'b1;
        step(1'b1);
        total++;
        if (err_cnt !== 8'd1 || err_cnt4 !== 4'd1 || err !== 1'b1) begin
            bad++;
            $display("FAIL clr_with_err: cnt=%0d/%0d err=%b required 1/1 1", err_cnt, err_cnt4, err);
        end
    endtask

    task automatic test_async_reset();
        step(1'b1);
        total++;
        if (err !== 1'b1 || err_cnt !== 8'd2 || locked !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset: err=%b cnt=%0d locked=%b required 1 2 1", err, err_cnt, locked);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (locked !== 1'b0 || err !== 1'b0 || err_cnt !== 8'd0 || err_cnt4 !== 4'd0) begin
            bad++;
            $display("FAIL async_reset: locked=%b err=%b cnt=%0d/%0d required 0 0 0/0", locked, err, err_cnt, err_cnt4);
        end
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_lock("gaps_relock", 1'b1, 8'd0, 4'd0);
    endtask

    initial begin
        test_reset();
        test_lock("lock", 1'b0, 8'd0, 4'd0);
        test_single_err();
        test_loss();
        test_sat_clr();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
